simon_sequence_engine: RTL and testbench

//  Game-sequence engine for the SIMON VGA design; sits directly upstream of block_controller.

---
 rtl/simon_pkg.sv | 45 ++++
 rtl/simon_lfsr16.sv | 26 ++
 rtl/simon_sequence_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_simon_sequence_engine.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON sequence engine: colour codes, FSM states,
// and the button/storage to colour-code helpers.
package simon_pkg;

  localparam logic [3:0] C_NONE   = 4'd0;
  localparam logic [3:0] C_RED    = 4'd1;
  localparam logic [3:0] C_BLUE   = 4'd2;
  localparam logic [3:0] C_YELLOW = 4'd3;
  localparam logic [3:0] C_GREEN  = 4'd4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADD   = 4'd1,
    S_SHOW  = 4'd2,
    S_GAP   = 4'd3,
    S_INPUT = 4'd4,
    S_ECHO  = 4'd5,
    S_PAUSE = 4'd6,
    S_WIN   = 4'd7,
    S_LOSE  = 4'd8
  } state_e;

  // Simultaneous presses resolve red > blue > yellow > green.
  function automatic logic [3:0] btn_to_code(input logic u, input logic r,
                                             input logic d, input logic l);
    logic [3:0] code;
    if (u) begin
      code = C_RED;
    end else if (r) begin
      code = C_BLUE;
    end else if (d) begin
      code = C_YELLOW;
    end else if (l) begin
      code = C_GREEN;
    end else begin
      code = C_NONE;
    end
    return code;
  endfunction

  function automatic logic [3:0] seq_to_code(input logic [1:0] s);
    return {2'b00, s} + 4'd1;
  endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
module simon_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Shift register, reloads the seed on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/simon_sequence_engine.sv
// SIMON game engine: grows a random colour sequence, plays it back on
// gColorNum, checks the player's echo and reports win/lose.
module simon_sequence_engine
  import simon_pkg::*;
#(
  parameter int          MAX_LEN       = 16,
  parameter int          SHOW_TICKS    = 4,
  parameter int          GAP_TICKS     = 2,
  parameter int          ECHO_TICKS    = 2,
  parameter int          TIMEOUT_TICKS = 40,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       btnu,
  input  logic       btnr,
  input  logic       btnd,
  input  logic       btnl,
  output logic [3:0] gColorNum,
  output logic [7:0] level,
  output logic       awaiting,
  output logic       win,
  output logic       lose
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = IW + 1;
  localparam int TW = 16;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] ECHO_LAST = TW'(ECHO_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);

  state_e         state_q;
  logic [TW-1:0]  timer_q;
  logic [IW-1:0]  idx_q;
  logic [LW-1:0]  level_q;
  logic [3:0]     color_q;
  logic           awaiting_q;
  logic           win_q;
  logic           lose_q;
  logic [1:0]     seq_q [MAX_LEN];

  logic [15:0]    lfsr_s;
  logic           unused_lfsr_s;
  logic [TW-1:0]  tmr_last_s;
  logic           tmr_done_s;
  logic           press_s;
  logic [3:0]     press_code_s;
  logic [3:0]     exp_code_s;
  logic [3:0]     new_code_s;
  logic [3:0]     add_show_code_s;
  logic [3:0]     next_show_code_s;
  logic [IW-1:0]  idx_nxt_s;
  logic           idx_last_s;
  logic           level_full_s;

  simon_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr_s)
  );

  assign unused_lfsr_s    = ^lfsr_s[15:2];
  assign press_s          = btnu | btnr | btnd | btnl;
  assign press_code_s     = btn_to_code(btnu, btnr, btnd, btnl);
  assign exp_code_s       = seq_to_code(seq_q[idx_q]);
  assign new_code_s       = seq_to_code(lfsr_s[1:0]);
  assign idx_nxt_s        = idx_q + IW'(1);
  assign next_show_code_s = seq_to_code(seq_q[idx_nxt_s]);
  assign idx_last_s       = (({1'b0, idx_q} + LW'(1)) == level_q);
  assign level_full_s     = (level_q == LW'(MAX_LEN));
  // The first colour of a fresh game is being written in ADD, so bypass the array.
  assign add_show_code_s  = (level_q == LW'(0)) ? new_code_s : seq_to_code(seq_q[0]);

  // Last tick count for the timed state currently active.
  always_comb begin
    tmr_last_s = '0;
    case (state_q)
      S_SHOW:          tmr_last_s = SHOW_LAST;
      S_GAP, S_PAUSE:  tmr_last_s = GAP_LAST;
      S_ECHO:          tmr_last_s = ECHO_LAST;
      S_INPUT:         tmr_last_s = TO_LAST;
      default:         tmr_last_s = '0;
    endcase
  end

  assign tmr_done_s = tick && (timer_q == tmr_last_s);

  // Sequence storage is deliberately not reset; level marks the valid entries.
  always_ff @(posedge clk) begin
    if (state_q == S_ADD) begin
      seq_q[level_q[IW-1:0]] <= lfsr_s[1:0];
    end
  end

  // Game FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      level_q    <= '0;
      color_q    <= C_NONE;
      awaiting_q <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            state_q <= S_ADD;
            level_q <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            color_q <= C_NONE;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
          end
        end
        S_ADD: begin
          if (level_q < LW'(MAX_LEN)) begin
            level_q <= level_q + LW'(1);
          end
          idx_q   <= '0;
          timer_q <= '0;
          color_q <= add_show_code_s;
          state_q <= S_SHOW;
        end
        S_SHOW: begin
          if (tmr_done_s) begin
            state_q <= S_GAP;
            timer_q <= '0;
            color_q <= C_NONE;
          end else if (tick) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_GAP: begin
          if (tmr_done_s) begin
            timer_q <= '0;
            if (idx_last_s) begin
              idx_q      <= '0;
              awaiting_q <= 1'b1;
              state_q    <= S_INPUT;
            end else begin
              idx_q   <= idx_nxt_s;
              color_q <= next_show_code_s;
              state_q <= S_SHOW;
            end
          end else if (tick) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_INPUT: begin
          // A press on the same clk as the final tick takes precedence over timeout.
          if (press_s) begin
            awaiting_q <= 1'b0;
            timer_q    <= '0;
            if (press_code_s == exp_code_s) begin
              color_q <= press_code_s;
              state_q <= S_ECHO;
            end else begin
              lose_q  <= 1'b1;
              state_q <= S_LOSE;
            end
          end else if (tmr_done_s) begin
            awaiting_q <= 1'b0;
            timer_q    <= '0;
            lose_q     <= 1'b1;
            state_q    <= S_LOSE;
          end else if (tick) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_ECHO: begin
          if (tmr_done_s) begin
            timer_q <= '0;
            color_q <= C_NONE;
            if (!idx_last_s) begin
              idx_q      <= idx_nxt_s;
              awaiting_q <= 1'b1;
              state_q    <= S_INPUT;
            end else if (level_full_s) begin
              win_q   <= 1'b1;
              state_q <= S_WIN;
            end else begin
              state_q <= S_PAUSE;
            end
          end else if (tick) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_PAUSE: begin
          if (tmr_done_s) begin
            timer_q <= '0;
            state_q <= S_ADD;
          end else if (tick) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          timer_q    <= '0;
          idx_q      <= '0;
          level_q    <= '0;
          color_q    <= C_NONE;
          awaiting_q <= 1'b0;
          win_q      <= 1'b0;
          lose_q     <= 1'b0;
        end
      endcase
    end
  end

  assign gColorNum = color_q;
  assign level     = 8'(level_q);
  assign awaiting  = awaiting_q;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_simon_sequence_engine.sv
// Randomised game play against a phase/countdown model of the SIMON rules.
module tb_simon_sequence_engine;

  localparam int MAX_LEN = 2;
  localparam int SHOW_T  = 2;
  localparam int GAP_T   = 1;
  localparam int ECHO_T  = 1;
  localparam int TO_T    = 5;

  localparam int P_IDLE  = 0;
  localparam int P_ADD   = 1;
  localparam int P_SHOW  = 2;
  localparam int P_GAP   = 3;
  localparam int P_INPUT = 4;
  localparam int P_ECHO  = 5;
  localparam int P_PAUSE = 6;
  localparam int P_WIN   = 7;
  localparam int P_LOSE  = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic       start = 1'b0;
  logic       btnu  = 1'b0;
  logic       btnr  = 1'b0;
  logic       btnd  = 1'b0;
  logic       btnl  = 1'b0;
  logic [3:0] gColorNum;
  logic [7:0] level;
  logic       awaiting;
  logic       win;
  logic       lose;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // model state: phase, ticks remaining, playback/echo position, sequence of colours
  int          ph;
  int          left;
  int          pos;
  int          echo_c;
  int          epoch = 0;
  int          mseq[$];
  logic [15:0] m_lfsr;

  simon_sequence_engine #(
    .MAX_LEN       (MAX_LEN),
    .SHOW_TICKS    (SHOW_T),
    .GAP_TICKS     (GAP_T),
    .ECHO_TICKS    (ECHO_T),
    .TIMEOUT_TICKS (TO_T),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .btnu      (btnu),
    .btnr      (btnr),
    .btnd      (btnd),
    .btnl      (btnl),
    .gColorNum (gColorNum),
    .level     (level),
    .awaiting  (awaiting),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic int pressed_colour();
    if (btnu) return 1;
    if (btnr) return 2;
    if (btnd) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    ph     = P_IDLE;
    left   = 0;
    pos    = 0;
    echo_c = 0;
    mseq.delete();
    m_lfsr = 16'hACE1;
  endtask

  task automatic enter_input();
    ph   = P_INPUT;
    left = TO_T;
    epoch++;
  endtask

  task automatic model_step();
    logic [15:0] prev;
    int p;
    prev   = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    case (ph)
      P_IDLE, P_WIN, P_LOSE: begin
        if (start) begin
          mseq.delete();
          ph = P_ADD;
        end
      end
      P_ADD: begin
        mseq.push_back(int'(prev[1:0]) + 1);
        pos  = 0;
        ph   = P_SHOW;
        left = SHOW_T;
      end
      P_SHOW: begin
        if (tick) begin
          left--;
          if (left == 0) begin
            ph   = P_GAP;
            left = GAP_T;
          end
        end
      end
      P_GAP: begin
        if (tick) begin
          left--;
          if (left == 0) begin
            if (pos + 1 == mseq.size()) begin
              pos = 0;
              enter_input();
            end else begin
              pos++;
              ph   = P_SHOW;
              left = SHOW_T;
            end
          end
        end
      end
      P_INPUT: begin
        if (btnu || btnr || btnd || btnl) begin
          p = pressed_colour();
          if (p == mseq[pos]) begin
            ph     = P_ECHO;
            echo_c = p;
            left   = ECHO_T;
          end else begin
            ph = P_LOSE;
          end
        end else if (tick) begin
          left--;
          if (left == 0) ph = P_LOSE;
        end
      end
      P_ECHO: begin
        if (tick) begin
          left--;
          if (left == 0) begin
            if (pos + 1 < mseq.size()) begin
              pos++;
              enter_input();
            end else if (mseq.size() == MAX_LEN) begin
              ph = P_WIN;
            end else begin
              ph   = P_PAUSE;
              left = GAP_T;
            end
          end
        end
      end
      P_PAUSE: begin
        if (tick) begin
          left--;
          if (left == 0) ph = P_ADD;
        end
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic compare();
    int ec;
    if (ph == P_SHOW) ec = mseq[pos];
    else if (ph == P_ECHO) ec = echo_c;
    else ec = 0;
    chk("gColorNum", gColorNum, ec);
    chk("level", level, mseq.size());
    chk("awaiting", awaiting, ph == P_INPUT);
    chk("win", win, ph == P_WIN);
    chk("lose", lose, ph == P_LOSE);
  endtask

  // model advances on every clock edge and on reset assertion
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // compare on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      compare();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick  = (cyc % 4 == 0);
    start = 1'b0;
    btnu  = 1'b0;
    btnr  = 1'b0;
    btnd  = 1'b0;
    btnl  = 1'b0;
  endtask

  task automatic press(input int c);
    case (c)
      1:       btnu = 1'b1;
      2:       btnr = 1'b1;
      3:       btnd = 1'b1;
      default: btnl = 1'b1;
    endcase
  endtask

  initial begin
    int last_epoch;
    int mode;
    int dly;
    int e;
    last_epoch = -1;
    mode       = 0;
    dly        = 0;

    repeat (3) step();
    rst   = 1'b0;
    start = 1'b1;
    step();
    step();
    // seed 0xACE1 steps once to 0x59C3 before ADD samples it: low bits 3 -> green
    chk("first_colour", gColorNum, 4);
    chk("first_level", level, 1);

    for (int i = 0; i < 200 && ph != P_INPUT; i++) step();
    chk("awaiting_round1", awaiting, 1);

    // red+green together resolves to red, which is wrong against green
    btnu = 1'b1;
    btnl = 1'b1;
    step();
    chk("dual_press_red_loses", lose, 1);
    chk("dual_press_not_awaiting", awaiting, 0);

    start = 1'b1;
    step();
    step();
    chk("restart_level", level, 1);
    chk("restart_showing", (gColorNum >= 4'd1) && (gColorNum <= 4'd4), 1);

    rst = 1'b1;
    #1;
    chk("rst_async_colour", gColorNum, 0);
    chk("rst_async_level", level, 0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 6000; i++) begin
      if (ph == P_INPUT) begin
        if (epoch != last_epoch) begin
          last_epoch = epoch;
          mode       = $urandom_range(0, 10);
          dly        = $urandom_range(0, 6);
        end
        e = mseq[pos];
        if (mode <= 6) begin
          if (dly == 0) press(e);
          else dly--;
        end else if (mode == 7) begin
          if (dly == 0) press((e % 4) + 1);
          else dly--;
        end else if (mode == 8) begin
          dly = 0;
        end else if (mode == 9) begin
          if (left == 1 && tick) press(e);
        end else begin
          if (dly == 0) begin
            btnu = 1'($urandom_range(0, 1));
            btnr = 1'($urandom_range(0, 1));
            btnd = 1'($urandom_range(0, 1));
            btnl = 1'b1;
          end else begin
            dly--;
          end
        end
      end else begin
        if ($urandom_range(0, 99) < 3) press($urandom_range(1, 4));
        if (ph == P_IDLE || ph == P_WIN || ph == P_LOSE) start = ($urandom_range(0, 3) == 0);
        else start = ($urandom_range(0, 99) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
